// File: rtl/search_vec_seq_if.sv
// Stream bundle for search_vec_seq: element input stream, mode select and result stream.
// The master side is the producer/consumer pair, the slave side is the search block.
interface search_vec_seq_if #(
  parameter int W       = 8,
  parameter int MAX_LEN = 16
);
  localparam int IW = $clog2(MAX_LEN);
  localparam int LW = $clog2(MAX_LEN + 1);

  logic          io_in_valid;
  logic          io_in_ready;
  logic [W-1:0]  io_in_data;
  logic          io_in_last;
  logic          io_mode;
  logic          io_out_valid;
  logic          io_out_ready;
  logic [W-1:0]  io_out_v;
  logic [IW-1:0] io_out_idx;
  logic [LW-1:0] io_out_len;
  logic          io_out_trunc;

  modport master (
    output io_in_valid, io_in_data, io_in_last, io_mode, io_out_ready,
    input  io_in_ready, io_out_valid, io_out_v, io_out_idx, io_out_len, io_out_trunc
  );

  modport slave (
    input  io_in_valid, io_in_data, io_in_last, io_mode, io_out_ready,
    output io_in_ready, io_out_valid, io_out_v, io_out_idx, io_out_len, io_out_trunc
  );
endinterface

// File: rtl/search_vec_seq.sv
// Streaming argmin/argmax over a variable-length vector (1..MAX_LEN beats), one result beat per vector.
// Optional max search is enabled by defining SEARCH_VEC_SEQ_MAX_MODE_EN; otherwise always minimum.
module search_vec_seq #(
  parameter int W       = 8,
  parameter int MAX_LEN = 16
) (
  input  logic           clock,
  input  logic           reset,
  search_vec_seq_if.slave io
);
  localparam int IW = $clog2(MAX_LEN);
  localparam int LW = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic [W-1:0]  best_v_r, best_v_s;
  logic [IW-1:0] best_idx_r, best_idx_s;
  logic [LW-1:0] cnt_r, cnt_s;
  logic [W-1:0]  out_v_r, out_v_s;
  logic [IW-1:0] out_idx_r, out_idx_s;
  logic [LW-1:0] out_len_r, out_len_s;
  logic          out_trunc_r, out_trunc_s;

  logic          in_fire_s;
  logic          out_fire_s;
  logic          replace_s;
  logic [LW-1:0] cnt_inc_s;
  logic [W-1:0]  nxt_v_s;
  logic [IW-1:0] nxt_idx_s;

  assign in_fire_s  = io.io_in_valid && io.io_in_ready;
  assign out_fire_s = io.io_out_valid && io.io_out_ready;
  assign cnt_inc_s  = cnt_r + LW'(1'b1);

`ifdef SEARCH_VEC_SEQ_MAX_MODE_EN
  logic mode_r, mode_s;
  // Strict compare keeps the earliest index on ties.
  assign replace_s = mode_r ? (io.io_in_data > best_v_r) : (io.io_in_data < best_v_r);
`else
  logic unused_mode_s;
  assign unused_mode_s = io.io_mode;
  assign replace_s     = (io.io_in_data < best_v_r);
`endif

  assign nxt_v_s   = replace_s ? io.io_in_data : best_v_r;
  assign nxt_idx_s = replace_s ? IW'(cnt_r) : best_idx_r;

  // Next-state and datapath update for the search FSM.
  always_comb begin
    state_s     = state_r;
    best_v_s    = best_v_r;
    best_idx_s  = best_idx_r;
    cnt_s       = cnt_r;
    out_v_s     = out_v_r;
    out_idx_s   = out_idx_r;
    out_len_s   = out_len_r;
    out_trunc_s = out_trunc_r;
`ifdef SEARCH_VEC_SEQ_MAX_MODE_EN
    mode_s      = mode_r;
`endif
    case (state_r)
      IDLE: begin
        if (in_fire_s) begin
          best_v_s   = io.io_in_data;
          best_idx_s = '0;
          cnt_s      = LW'(1'b1);
`ifdef SEARCH_VEC_SEQ_MAX_MODE_EN
          mode_s     = io.io_mode;
`endif
          if (io.io_in_last) begin
            state_s     = DONE;
            out_v_s     = io.io_in_data;
            out_idx_s   = '0;
            out_len_s   = LW'(1'b1);
            out_trunc_s = 1'b0;
          end else begin
            state_s = ACCUM;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ACCUM: begin
        if (in_fire_s) begin
          best_v_s   = nxt_v_s;
          best_idx_s = nxt_idx_s;
          cnt_s      = cnt_inc_s;
          // A full vector without last is force-terminated and flagged.
          if (io.io_in_last || (cnt_inc_s == LW'(MAX_LEN))) begin
            state_s     = DONE;
            out_v_s     = nxt_v_s;
            out_idx_s   = nxt_idx_s;
            out_len_s   = cnt_inc_s;
            out_trunc_s = !io.io_in_last;
          end else begin
            state_s = ACCUM;
          end
        end else begin
          state_s = ACCUM;
        end
      end
      DONE: begin
        if (out_fire_s) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      best_v_r    <= '0;
      best_idx_r  <= '0;
      cnt_r       <= '0;
      out_v_r     <= '0;
      out_idx_r   <= '0;
      out_len_r   <= '0;
      out_trunc_r <= 1'b0;
`ifdef SEARCH_VEC_SEQ_MAX_MODE_EN
      mode_r      <= 1'b0;
`endif
    end else begin
      state_r     <= state_s;
      best_v_r    <= best_v_s;
      best_idx_r  <= best_idx_s;
      cnt_r       <= cnt_s;
      out_v_r     <= out_v_s;
      out_idx_r   <= out_idx_s;
      out_len_r   <= out_len_s;
      out_trunc_r <= out_trunc_s;
`ifdef SEARCH_VEC_SEQ_MAX_MODE_EN
      mode_r      <= mode_s;
`endif
    end
  end

  assign io.io_in_ready  = !reset && (state_r != DONE);
  assign io.io_out_valid = (state_r == DONE);
  assign io.io_out_v     = out_v_r;
  assign io.io_out_idx   = out_idx_r;
  assign io.io_out_len   = out_len_r;
  assign io.io_out_trunc = out_trunc_r;
endmodule

// File: tb/tb_search_vec_seq.sv
// Self-checking bench for search_vec_seq: directed vector table, corner-case sequences
// and a randomized run scored against a queue-based argmin/argmax model.
module tb_search_vec_seq;
  localparam int W       = 8;
  localparam int MAX_LEN = 16;
  localparam int IW      = 4;
  localparam int LW      = 5;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  search_vec_seq_if #(.W(W), .MAX_LEN(MAX_LEN)) io();

  search_vec_seq #(.W(W), .MAX_LEN(MAX_LEN)) dut (
    .clock (clock),
    .reset (reset),
    .io    (io.slave)
  );

  typedef struct packed {
    logic [W-1:0]  v;
    logic [IW-1:0] idx;
    logic [LW-1:0] len;
    logic          trunc;
  } res_t;

  typedef struct packed {
    logic [W-1:0] d;
    logic         last;
  } beat_t;

  typedef struct {
    int               n;
    logic             mode;
    logic [15:0][7:0] d;
    res_t             exp;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  vec_t tv[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic res_t dut_res();
    dut_res = {io.io_out_v, io.io_out_idx, io.io_out_len, io.io_out_trunc};
  endfunction

  // Reference: scan the stored vector; strict compare keeps the earliest extreme.
  function automatic res_t model_result(input logic [7:0] q[$], input logic m, input logic by_last);
    res_t r;
    int   b = 0;
    for (int i = 1; i < q.size(); i++) begin
      if (m ? (q[i] > q[b]) : (q[i] < q[b])) b = i;
    end
    r.v     = q[b];
    r.idx   = b[IW-1:0];
    r.len   = LW'(q.size());
    r.trunc = !by_last;
    return r;
  endfunction

  function automatic logic eff_mode(input logic m);
`ifdef SEARCH_VEC_SEQ_MAX_MODE_EN
    return m;
`else
    return 1'b0 & m;
`endif
  endfunction

  function automatic void add_vec(input int n, input logic m, input logic [127:0] d, input res_t e);
    vec_t t;
    t.n = n; t.mode = m; t.d = d; t.exp = e;
    tv.push_back(t);
  endfunction

  // Drives one table vector from IDLE; io_mode flips after the first beat to prove it is latched.
  task automatic run_vec(input vec_t t, input int k);
    io.io_out_ready = 1'b1;
    for (int i = 0; i < t.n; i++) begin
      io.io_in_valid = 1'b1;
      io.io_in_data  = t.d[i];
      io.io_in_last  = (i == t.n - 1);
      io.io_mode     = (i == 0) ? t.mode : ~t.mode;
      check($sformatf("tbl%0d_in_ready", k), 32'(io.io_in_ready), 32'd1);
      tick();
    end
    io.io_in_valid = 1'b0;
    io.io_in_last  = 1'b0;
    check($sformatf("tbl%0d_latency", k), 32'(io.io_out_valid), 32'd1);
    check($sformatf("tbl%0d_result", k), 32'(dut_res()), 32'(t.exp));
    tick();
    check($sformatf("tbl%0d_back_idle", k), {30'd0, io.io_in_ready, io.io_out_valid}, 32'h2);
  endtask

  initial begin
    logic [15:0][7:0] dd;
    beat_t  beats[$];
    res_t   expq[$];
    res_t   r;
    logic [7:0] cur[$];
    logic   cur_mode;
    int     p, got, bubbles, cyc, n_vec;

    io.io_in_valid  = 1'b0;
    io.io_in_data   = 8'd0;
    io.io_in_last   = 1'b0;
    io.io_mode      = 1'b0;
    io.io_out_ready = 1'b0;
    reset           = 1'b1;

    // Reset state
    tick(); tick();
    check("rst_in_ready_low", 32'(io.io_in_ready), 32'd0);
    check("rst_out_state", {13'd0, io.io_out_valid, dut_res()}, 32'd0);
    reset = 1'b0;
    #1;
    check("rst_in_ready_after", 32'(io.io_in_ready), 32'd1);

    // Directed table (element 0 is the rightmost byte)
    add_vec(5, 1'b0, 128'({8'd5, 8'd3, 8'd9, 8'd3, 8'd7}), {8'd3, 4'd1, 5'd5, 1'b0});
    add_vec(1, 1'b0, 128'({8'h55}),                         {8'h55, 4'd0, 5'd1, 1'b0});
    add_vec(2, 1'b0, 128'({8'd2, 8'd5}),                    {8'd2, 4'd1, 5'd2, 1'b0});
    add_vec(2, 1'b0, 128'({8'd9, 8'd8}),                    {8'd8, 4'd0, 5'd2, 1'b0});
    add_vec(3, 1'b0, 128'({8'd0, 8'd0, 8'd0}),              {8'd0, 4'd0, 5'd3, 1'b0});
    add_vec(3, 1'b0, 128'({8'd255, 8'd254, 8'd255}),        {8'd254, 4'd1, 5'd3, 1'b0});
    for (int i = 0; i < 16; i++) dd[i] = 8'(16 - i);
    add_vec(16, 1'b0, dd, {8'd1, 4'd15, 5'd16, 1'b0});
`ifdef SEARCH_VEC_SEQ_MAX_MODE_EN
    add_vec(4, 1'b1, 128'({8'd4, 8'd200, 8'd200, 8'd10}),  {8'd200, 4'd1, 5'd4, 1'b0});
    add_vec(3, 1'b1, 128'({8'd255, 8'd0, 8'd0}),           {8'd255, 4'd2, 5'd3, 1'b0});
`endif
    for (int k = 0; k < tv.size(); k++) run_vec(tv[k], k);
    io.io_mode = 1'b0;

    // Backpressure: result held stable while consumer stalls
    io.io_out_ready = 1'b0;
    io.io_in_valid  = 1'b1; io.io_in_data = 8'h55; io.io_in_last = 1'b1;
    tick();
    io.io_in_valid  = 1'b0; io.io_in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("hold_stable", {12'd0, io.io_in_ready, io.io_out_valid, dut_res()},
            {12'd0, 1'b0, 1'b1, 8'h55, 4'd0, 5'd1, 1'b0});
      tick();
    end
    io.io_out_ready = 1'b1;
    tick();
    check("hold_release", {30'd0, io.io_in_ready, io.io_out_valid}, 32'h2);

    // Truncation at MAX_LEN; the 17th beat starts a new vector
    for (int i = 0; i < 16; i++) begin
      io.io_in_valid = 1'b1; io.io_in_data = 8'(16 - i); io.io_in_last = 1'b0;
      tick();
    end
    io.io_in_data = 8'd0;
    check("trunc_result", {13'd0, io.io_out_valid, dut_res()}, {13'd0, 1'b1, 8'd1, 4'd15, 5'd16, 1'b1});
    check("trunc_in_ready", 32'(io.io_in_ready), 32'd0);
    tick();
    check("trunc_idle", {30'd0, io.io_in_ready, io.io_out_valid}, 32'h2);
    tick();
    io.io_in_data = 8'd7; io.io_in_last = 1'b1;
    tick();
    io.io_in_valid = 1'b0; io.io_in_last = 1'b0;
    check("trunc_next_vec", {13'd0, io.io_out_valid, dut_res()}, {13'd0, 1'b1, 8'd0, 4'd0, 5'd2, 1'b0});
    tick();

    // Back-to-back vectors with one bubble
    beats = '{'{8'd5, 1'b0}, '{8'd2, 1'b1}, '{8'd8, 1'b0}, '{8'd9, 1'b1}};
    expq  = '{{8'd2, 4'd1, 5'd2, 1'b0}, {8'd8, 4'd0, 5'd2, 1'b0}};
    p = 0; got = 0; bubbles = 0;
    for (cyc = 0; cyc < 20 && (p < 4 || got < 2); cyc++) begin
      io.io_in_valid = (p < 4);
      if (p < 4) begin
        io.io_in_data = beats[p].d; io.io_in_last = beats[p].last;
      end
      if (io.io_out_valid) begin
        check("b2b_result", 32'(dut_res()), 32'(expq[got]));
        got++;
      end
      if (p < 4) begin
        if (io.io_in_ready) p++;
        else bubbles++;
      end
      tick();
    end
    io.io_in_valid = 1'b0; io.io_in_last = 1'b0;
    check("b2b_bubbles", 32'(bubbles), 32'd1);
    check("b2b_results_seen", 32'(got), 32'd2);

    // Reset mid-vector discards the partial vector
    for (int i = 0; i < 3; i++) begin
      io.io_in_valid = 1'b1; io.io_in_data = 8'(i + 1); io.io_in_last = 1'b0;
      tick();
    end
    io.io_in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_ready_low", {30'd0, io.io_in_ready, io.io_out_valid}, 32'h0);
    tick();
    reset = 1'b0;
    #1;
    check("midrst_idle", {30'd0, io.io_in_ready, io.io_out_valid}, 32'h2);
    io.io_in_valid = 1'b1; io.io_in_data = 8'd4; io.io_in_last = 1'b1;
    tick();
    io.io_in_valid = 1'b0; io.io_in_last = 1'b0;
    check("midrst_next_vec", {13'd0, io.io_out_valid, dut_res()}, {13'd0, 1'b1, 8'd4, 4'd0, 5'd1, 1'b0});
    tick();

    // Reset while a result is pending drops it
    io.io_out_ready = 1'b0;
    io.io_in_valid = 1'b1; io.io_in_data = 8'h9A; io.io_in_last = 1'b1;
    tick();
    io.io_in_valid = 1'b0; io.io_in_last = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rstres_cleared", {13'd0, io.io_out_valid, dut_res()}, 32'd0);

    // Randomized traffic against the queue model
    beats.delete(); expq.delete(); cur.delete();
    n_vec = 250;
    for (int v = 0; v < n_vec; v++) begin
      int len;
      bit narrow;
      len    = $urandom_range(1, 20);
      narrow = 1'($urandom_range(0, 1));
      for (int j = 0; j < len; j++)
        beats.push_back({narrow ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255)), j == len - 1});
    end
    p = 0; cur_mode = 1'b0;
    for (cyc = 0; cyc < 40000 && (p < beats.size() || expq.size() != 0); cyc++) begin
      io.io_in_valid  = (p < beats.size()) && ($urandom_range(0, 9) < 7);
      io.io_in_data   = (p < beats.size()) ? beats[p].d : 8'd0;
      io.io_in_last   = (p < beats.size()) ? beats[p].last : 1'b0;
      io.io_mode      = 1'($urandom_range(0, 1));
      io.io_out_ready = ($urandom_range(0, 9) < 6);
      #1;
      if (io.io_out_valid && io.io_in_ready) check("rand_ready_while_valid", 32'd1, 32'd0);
      if (io.io_out_valid && io.io_out_ready) begin
        if (expq.size() == 0) begin
          check("rand_unexpected_result", 32'(dut_res()), 32'hFFFFFFFF);
        end else begin
          r = expq.pop_front();
          check("rand_result", 32'(dut_res()), 32'(r));
        end
      end
      if (io.io_in_valid && io.io_in_ready) begin
        if (cur.size() == 0) cur_mode = eff_mode(io.io_mode);
        cur.push_back(io.io_in_data);
        if (io.io_in_last || cur.size() == MAX_LEN) begin
          expq.push_back(model_result(cur, cur_mode, io.io_in_last));
          cur.delete();
        end
        p++;
      end
      tick();
    end
    check("rand_completed", {15'd0, 1'(expq.size() != 0), 16'(beats.size() - p)}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/search_vec_seq.md
# search_vec_seq

Streaming, parametrised successor to the combinational vector minimum search. Accepts a vector one element per beat over a valid/ready stream of any length from 1 to `MAX_LEN`. Tracks the running extreme value and its index, then presents a single result beat: value, index, length and truncation flag. Sits between a sample producer and any consumer needing argmin/argmax, replacing fixed-size comparator trees where vector length varies at run time.

## Interface
Parameters:
- `W`, 8: element width in bits (unsigned).
- `MAX_LEN`, 16: maximum elements per vector; ≥ 2.
- `IW`, `$clog2(MAX_LEN)`: index width (derived, not overridable).
- `LW`, `$clog2(MAX_LEN+1)`: length width (derived).

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clock`  in  1  sole clock, rising edge.
  - `reset`  in  1  synchronous, active-high reset.
- Input stream:
  - `io_in_valid`  in  1  element beat valid.
  - `io_in_ready`  out  1  block accepts the beat.
  - `io_in_data`  in  W  unsigned element.
  - `io_in_last`  in  1  final element of the vector.
  - `io_mode`  in  1  0 = min, 1 = max; sampled on the first beat of a vector.
- Result stream:
  - `io_out_valid`  out  1  result beat valid.
  - `io_out_ready`  in  1  consumer accepts the result.
  - `io_out_v`  out  W  extreme value.
  - `io_out_idx`  out  IW  zero-based index of the extreme.
  - `io_out_len`  out  LW  number of elements consumed.
  - `io_out_trunc`  out  1  vector was force-terminated at `MAX_LEN`.

## Operation
- Transfer rules:
  - An input beat transfers when `io_in_valid && io_in_ready`.
  - A result beat transfers when `io_out_valid && io_out_ready`.
- FSM states:
  - IDLE: `io_in_ready`=1. A transfer loads best_v=data, best_idx=0, cnt=1, and latches mode.
    - If `io_in_last`, go to DONE.
    - Otherwise go to ACCUM.
  - ACCUM: `io_in_ready`=1. A transfer compares data to best_v.
    - Replace when data < best_v (min mode) or data > best_v (max mode). Comparison is strict, so on ties the earliest index wins.
    - On a replace, best_idx = cnt. cnt increments on every transfer.
    - Go to DONE on `io_in_last`, or when cnt reaches `MAX_LEN` with last=0. In the second case set trunc=1.
  - DONE: `io_in_ready`=0, `io_out_valid`=1. Outputs are held stable until the result transfers, then go to IDLE.
- Truncation:
  - A truncated vector ends the search. Further beats of the same vector arrive in IDLE and are treated as a new vector.
  - `io_out_len` = `MAX_LEN` when truncated.
- Mode is latched on the first beat. Changes to `io_mode` mid-vector are ignored.
- Arithmetic:
  - Comparison is unsigned, W bits.
  - cnt saturates structurally at `MAX_LEN` (it never exceeds it).
  - Output index is zero-extended to IW.

## Timing
- Reset:
  - State = IDLE.
  - `io_out_valid`=0, `io_out_v`=0, `io_out_idx`=0, `io_out_len`=0, `io_out_trunc`=0.
  - `io_in_ready`=0 while reset is high, 1 in the first cycle after.
- Latency: `io_out_valid` rises the cycle after the last (or `MAX_LEN`-th) beat transfers.
- Throughput:
  - Input: one element per cycle.
  - Minimum gap between vectors: one cycle, the DONE cycle in which `io_out_ready` is sampled.
  - No new input is accepted while `io_out_valid`=1.
- Result transfer: on the transfer cycle the block returns to IDLE. `io_in_ready`=1 on the next cycle.
- Reset mid-vector or mid-result: partial state is discarded with no result emitted, and the block is in IDLE on the next cycle.
- `io_out_*` data may change only in the cycle after a result transfer or reset.

## Configuration
- Macro: `SEARCH_VEC_SEQ_MAX_MODE_EN`.
- Defined: `io_mode` is honoured and both min and max search are available.
- Undefined:
  - The max comparator and mode latch are compiled out. The block always searches for the minimum.
  - `io_mode` remains a port but is ignored.

## Test plan
- W=8, MAX_LEN=16, min mode. Stream 7,3,9,3,5 with last on 5 → result v=3, idx=1, len=5, trunc=0, valid one cycle after the last beat.
- Max mode (macro defined). Stream 10,200,200,4 → v=200, idx=1, len=4. Toggling `io_mode` to 0 after the first beat must not change the result.
- Single beat 0x55 with last → v=0x55, idx=0, len=1. Hold `io_out_ready`=0 for 5 cycles: outputs stable, `io_in_ready`=0. Release: the result transfers, `io_in_ready`=1 on the next cycle.
- Stream 17 beats, values 16 down to 0, last never set → result v=1, idx=15, len=16, trunc=1. The 17th beat (value 0) forms a new vector.
- Back-to-back vectors with `io_out_ready` tied to 1: stream 5,2(last) then 8,9(last) → results (2,1,2) then (8,0,2), with exactly one bubble cycle on `io_in_ready` between the vectors.
- Assert reset for one cycle after 3 beats of a vector → no `io_out_valid`. A following vector 4(last) yields v=4, idx=0, len=1.
